// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction BRAM address,
// strobes f_valid once read data is valid, and advances on back-end retire events.
module fetch_ctrl #(
  parameter int                 ADDR_W   = 14,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              halt,
  input  logic              write_finish,
  input  logic              store_finish,
  input  logic              jump_finish,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              uart_send_valid,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              f_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       instret,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, next_state;
  logic [ADDR_W-1:0] next_pc;
  logic              retire;
  logic              accept;

  // Simultaneous finish pulses collapse into a single retire.
  assign retire = write_finish | store_finish | jump_finish | uart_send_valid;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    accept     = 1'b0;
    unique case (state)
      S_IDLE:   if (start) next_state = S_ADDR;
      S_ADDR:   next_state = S_ISSUE;
      S_ISSUE:  next_state = S_WAIT;
      S_WAIT: begin
        if (retire) begin
          accept     = 1'b1;
          next_pc    = jump_finish ? jump_target : pc + PC_STEP;
          next_state = halt ? S_HALTED : S_ADDR;
        end
      end
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they
  // describe, with no combinational path from inputs to outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      f_valid   <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      instret   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= next_pc;
      imem_addr <= next_pc;
      f_valid   <= (next_state == S_ISSUE);
      busy      <= (next_state == S_ADDR) || (next_state == S_ISSUE) ||
                   (next_state == S_WAIT);
      halted    <= (next_state == S_HALTED);
      if (accept) instret <= instret + 32'd1;
      if (retire && state != S_WAIT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: expected PCs are queued when a retire is
// driven and popped when the DUT raises f_valid.
module tb_fetch_ctrl;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start, halt;
  logic              write_finish, store_finish, jump_finish, uart_send_valid;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] imem_addr, pc;
  logic              f_valid, busy, halted, err;
  logic [31:0]       instret;

  int n_pass  = 0;
  int n_total = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] model_pc;
  logic [31:0]       model_instret;
  logic              model_err;

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .halt(halt),
    .write_finish(write_finish), .store_finish(store_finish),
    .jump_finish(jump_finish), .jump_target(jump_target),
    .uart_send_valid(uart_send_valid), .imem_addr(imem_addr),
    .f_valid(f_valid), .pc(pc), .busy(busy), .halted(halted),
    .instret(instret), .err(err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    start = 0; halt = 0; write_finish = 0; store_finish = 0;
    jump_finish = 0; uart_send_valid = 0; jump_target = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc = '0; model_instret = '0; model_err = 1'b0;
  endtask

  // Checks every output against its reset value; used while rstn is low.
  task automatic test_reset(input string name);
    n_total++;
    if (pc !== '0 || imem_addr !== '0) begin
      $display("FAIL %s_addr: pc=%h imem_addr=%h, want 0/0", name, pc, imem_addr);
    end else n_pass++;
    n_total++;
    if ({f_valid, busy, halted, err} !== 4'b0000) begin
      $display("FAIL %s_flags: f_valid/busy/halted/err=%b, want 0000", name,
               {f_valid, busy, halted, err});
    end else n_pass++;
    n_total++;
    if (instret !== 32'd0) begin
      $display("FAIL %s_instret: got %0d, want 0", name, instret);
    end else n_pass++;
  endtask

  // Start from IDLE: ADDR on the next cycle, single f_valid one cycle later.
  task automatic test_start();
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model_pc);
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (imem_addr !== model_pc || busy !== 1'b1 || f_valid !== 1'b0) begin
      $display("FAIL start_addr: imem_addr=%h busy=%b f_valid=%b, want %h/1/0",
               imem_addr, busy, f_valid, model_pc);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (f_valid !== 1'b1 || exp_q.size() == 0 || pc !== exp_q[0]) begin
      $display("FAIL start_issue: f_valid=%b pc=%h, want 1/%h", f_valid, pc, model_pc);
    end else n_pass++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    n_total++;
    if (f_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL start_pulse: f_valid=%b busy=%b, want 0/1", f_valid, busy);
    end else n_pass++;
  endtask

  // Drives one retire in WAIT, then checks the PC update and the issue that follows.
  task automatic do_retire(input string name, input logic w, input logic s,
                           input logic j, input logic u,
                           input logic [ADDR_W-1:0] tgt, input logic h);
    logic fv_seen;
    @(negedge clk);
    write_finish = w; store_finish = s; jump_finish = j; uart_send_valid = u;
    jump_target = tgt; halt = h;
    model_pc      = j ? tgt : model_pc + 1'b1;
    model_instret = model_instret + 32'd1;
    if (!h) exp_q.push_back(model_pc);
    @(negedge clk);
    clear_inputs();
    if (h) begin
      n_total++;
      if (halted !== 1'b1 || busy !== 1'b0) begin
        $display("FAIL %s_halted: halted=%b busy=%b, want 1/0", name, halted, busy);
      end else n_pass++;
      fv_seen = 1'b0;
      repeat (6) begin
        if (f_valid !== 1'b0) fv_seen = 1'b1;
        @(negedge clk);
      end
      n_total++;
      if (fv_seen !== 1'b0) begin
        $display("FAIL %s_no_fetch: f_valid seen after halt=%b, want 0", name, fv_seen);
      end else n_pass++;
    end else begin
      n_total++;
      if (pc !== model_pc || imem_addr !== model_pc || busy !== 1'b1 || f_valid !== 1'b0) begin
        $display("FAIL %s_next_pc: pc=%h imem_addr=%h busy=%b f_valid=%b, want %h/%h/1/0",
                 name, pc, imem_addr, busy, f_valid, model_pc, model_pc);
      end else n_pass++;
      @(negedge clk);
      n_total++;
      if (f_valid !== 1'b1 || exp_q.size() == 0 || pc !== exp_q[0]) begin
        $display("FAIL %s_issue: f_valid=%b pc=%h, want 1/%h", name, f_valid, pc, model_pc);
      end else n_pass++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
      n_total++;
      if (f_valid !== 1'b0) begin
        $display("FAIL %s_pulse: f_valid=%b, want 0", name, f_valid);
      end else n_pass++;
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      do_retire($sformatf("seq%0d", i), 1, 0, 0, 0, '0, 0);
    end
    n_total++;
    if (instret !== 32'd3 || err !== 1'b0 || pc !== 14'd3) begin
      $display("FAIL seq_totals: instret=%0d err=%b pc=%h, want 3/0/0003", instret, err, pc);
    end else n_pass++;
  endtask

  task automatic test_jump_priority();
    do_retire("jump_store", 0, 1, 1, 0, 14'h0100, 0);
    n_total++;
    if (instret !== model_instret) begin
      $display("FAIL jump_store_instret: got %0d, want %0d", instret, model_instret);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    do_retire("jump_top", 0, 0, 1, 0, 14'h3FFF, 0);
    do_retire("uart_wrap", 0, 0, 0, 1, 14'h1234, 0);
    n_total++;
    if (pc !== 14'h0000) begin
      $display("FAIL wrap_pc: got %h, want 0000", pc);
    end else n_pass++;
  endtask

  // A retire during ISSUE sets err without touching pc or instret.
  task automatic test_err_in_issue();
    @(negedge clk);
    write_finish = 1'b1;
    model_pc = model_pc + 1'b1;
    model_instret = model_instret + 32'd1;
    exp_q.push_back(model_pc);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    n_total++;
    if (f_valid !== 1'b1 || exp_q.size() == 0 || pc !== exp_q[0]) begin
      $display("FAIL err_pre_issue: f_valid=%b pc=%h, want 1/%h", f_valid, pc, model_pc);
    end else n_pass++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    write_finish = 1'b1;
    model_err = 1'b1;
    @(negedge clk);
    clear_inputs();
    n_total++;
    if (err !== model_err || pc !== model_pc || instret !== model_instret) begin
      $display("FAIL err_issue: err=%b pc=%h instret=%0d, want %b/%h/%0d",
               err, pc, instret, model_err, model_pc, model_instret);
    end else n_pass++;
    do_retire("after_err", 1, 0, 0, 0, '0, 0);
    n_total++;
    if (err !== 1'b1 || instret !== model_instret) begin
      $display("FAIL err_sticky: err=%b instret=%0d, want 1/%0d", err, instret, model_instret);
    end else n_pass++;
  endtask

  task automatic test_halt();
    do_retire("halt", 1, 0, 0, 0, '0, 1);
    n_total++;
    if (instret !== model_instret || halted !== 1'b1) begin
      $display("FAIL halt_final: instret=%0d halted=%b, want %0d/1",
               instret, halted, model_instret);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    test_start();
    do_retire("pre_reset", 1, 0, 0, 0, '0, 0);
    n_total++;
    if (busy !== 1'b1 || pc !== 14'd1) begin
      $display("FAIL pre_reset_state: busy=%b pc=%h, want 1/0001", busy, pc);
    end else n_pass++;
    #1 rstn = 1'b0;
    #1;
    model_reset();
    test_reset("reset_mid");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rstn = 1'b0;
    #2;
    test_reset("reset");
    @(negedge clk);
    rstn = 1'b1;
    test_start();
    test_sequential();
    test_jump_priority();
    test_wrap();
    test_err_in_issue();
    test_halt();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
